// File: rtl/t_counter_if.sv
// Control and status bundle for t_counter: the driver owns en/up/load/d,
// and the counter owns q/qbar/tc/wrap.
interface t_counter_if #(
    parameter int WIDTH = 4
);
    logic             en;
    logic             up;
    logic             load;
    logic [WIDTH-1:0] d;
    logic [WIDTH-1:0] q;
    logic [WIDTH-1:0] qbar;
    logic             tc;
    logic             wrap;

    modport master (output en, up, load, d, input q, qbar, tc, wrap);
    modport slave  (input en, up, load, d, output q, qbar, tc, wrap);
endinterface

// File: rtl/t_counter.sv
// Modulo-MODULUS up/down counter with T-flip-flop hold/step semantics, clamped load,
// terminal count and wrap pulse. Define T_COUNTER_SAT_EN to saturate instead of wrap.
module t_counter #(
    parameter int WIDTH   = 4,
    parameter int MODULUS = 10
) (
    input  logic        clk,
    input  logic        rst,
    t_counter_if.slave  bus
);

    localparam logic [WIDTH-1:0] MAX_Q = WIDTH'(MODULUS - 1);

    generate
        if (WIDTH < 1 || MODULUS < 2 || longint'(MODULUS) > (longint'(1) << WIDTH)) begin : g_param_check
            $error("t_counter: need WIDTH >= 1 and 2 <= MODULUS <= 2**WIDTH");
        end
    endgenerate

    logic [WIDTH-1:0] q_r;
    logic             wrap_r;
    logic [WIDTH-1:0] q_next;
    logic             wrap_next;
    logic             tc;
    logic [WIDTH-1:0] q_step;

    // Out-of-range load values clamp to the top of the count range.
    function automatic logic [WIDTH-1:0] clamp_load(input logic [WIDTH-1:0] v);
        return (v > MAX_Q) ? MAX_Q : v;
    endfunction

    function automatic logic [WIDTH-1:0] step(input logic [WIDTH-1:0] cur, input logic dir_up);
        if (dir_up)
            return (cur == MAX_Q) ? '0 : cur + 1'b1;
        else
            return (cur == '0) ? MAX_Q : cur - 1'b1;
    endfunction

    always_comb begin
        tc     = bus.en & (bus.up ? (q_r == MAX_Q) : (q_r == '0));
        q_step = step(q_r, bus.up);
    end

    always_comb begin
        q_next    = q_r;
        wrap_next = 1'b0;
        if (bus.load) begin
            q_next = clamp_load(bus.d);
        end else if (bus.en) begin
`ifdef T_COUNTER_SAT_EN
            // At the terminal value tc is high: hold there, and flag only the entering edge.
            if (!tc) begin
                q_next    = q_step;
                wrap_next = (q_step == (bus.up ? MAX_Q : '0));
            end
`else
            q_next    = q_step;
            wrap_next = tc;
`endif
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            q_r    <= '0;
            wrap_r <= 1'b0;
        end else begin
            q_r    <= q_next;
            wrap_r <= wrap_next;
        end
    end

    assign bus.q    = q_r;
    assign bus.qbar = ~q_r;
    assign bus.tc   = tc;
    assign bus.wrap = wrap_r;

endmodule
